nios_pio_in_edge: RTL

NIOS_PIO_IN_EDGE -- requirements
Module: nios_pio_in_edge

---
 rtl/nios_pio_in_edge.sv | 135 +++++++++++++
 1 files changed

// File: rtl/nios_pio_in_edge.sv
// Avalon-MM parallel input port: synchronised, optionally debounced inputs with sticky edge capture and a masked level irq.
// Latency: readdata 1 clock after address; in_port to stable 2 clocks (+DEBOUNCE_CYCLES); stable change to capture/irq 1 more clock.
// Backpressure: none; the slave accepts every write and returns read data on the following clock.
module nios_pio_in_edge #(
    parameter int WIDTH           = 10,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_capture;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      r_readdata;
    logic [31:0]      w_rdata_nxt;
    logic             w_wr;
    logic             w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    // Bits above WIDTH are deliberately dropped on every register write.
    assign w_unused_wdata = ^writedata;
    assign w_clr          = (w_wr && address == 2'd3) ? w_wdata : '0;

    // Two-flop synchroniser for the asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign w_stable = r_sync2;
        end else begin : g_debounce
            // Counter compares against N-1 so the load happens on the clock the count would reach N;
            // it is cleared on load, so it never exceeds N and cannot wrap.
            localparam logic [15:0] LP_LAST = 16'(DEBOUNCE_CYCLES - 1);

            logic [15:0]      r_cnt [WIDTH];
            logic [WIDTH-1:0] r_stable;

            // Per-bit stability counters: a bit only moves after N consecutive disagreeing clocks.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_stable <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (r_sync2[i] == r_stable[i]) begin
                            r_cnt[i] <= '0;
                        end else if (r_cnt[i] == LP_LAST) begin
                            r_stable[i] <= r_sync2[i];
                            r_cnt[i]    <= '0;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 16'd1;
                        end
                    end
                end
            end

            assign w_stable = r_stable;
        end
    endgenerate

    // Select which stable transitions count as events.
    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = w_stable & ~r_stable_d;
            1:       w_edge = ~w_stable & r_stable_d;
            default: w_edge = w_stable ^ r_stable_d;
        endcase
    end

    // Delayed stable copy, irq mask and sticky capture (a new event beats a same-clock clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_d <= '0;
            r_mask     <= '0;
            r_capture  <= '0;
        end else begin
            r_stable_d <= w_stable;
            r_capture  <= (r_capture & ~w_clr) | w_edge;
            if (w_wr && address == 2'd2) begin
                r_mask <= w_wdata;
            end
        end
    end

    // Read mux; unused upper bits and the reserved word read as zero.
    always_comb begin
        w_rdata_nxt = '0;
        case (address)
            2'd0:    w_rdata_nxt[WIDTH-1:0] = w_stable;
            2'd2:    w_rdata_nxt[WIDTH-1:0] = r_mask;
            2'd3:    w_rdata_nxt[WIDTH-1:0] = r_capture;
            default: w_rdata_nxt = '0;
        endcase
    end

    // Read data is registered every clock, independent of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata_nxt;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_capture & r_mask);

endmodule
